// File: rtl/filter_pkg.sv
// Shared constants and width/latency helpers for the filter datapath blocks.
// Everything here is a constant function so callers can size ports and generate loops.
package filter_pkg;

    localparam int PIX_W = 8;

    function automatic int CLOG2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int SUM_W_OF(input int n, input int w);
        return w + CLOG2(n);
    endfunction

    function automatic int LAT_OF(input int n);
        return CLOG2(n) + 2;
    endfunction

    // Operand count entering adder-tree level lvl (ceil(n / 2^lvl)).
    function automatic int LEVEL_OPS(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    // floor(2^s / n); with s >= sum width the quotient estimate is low by at most one.
    function automatic longint RECIP_OF(input int n, input int s);
        return (longint'(1) << s) / longint'(n);
    endfunction

endpackage

// File: rtl/window_sum_pipe_if.sv
// Window-in / sum-and-mean-out bundle between the window generator and the filter datapath.
// The master drives windows and the stall enable; the slave returns sum, mean and valid.
interface window_sum_pipe_if
    import filter_pkg::*;
#(
    parameter int N_IN   = 9,
    parameter int DATA_W = PIX_W
) ();

    localparam int SUM_W = SUM_W_OF(N_IN, DATA_W);

    logic                     en;
    logic                     in_valid;
    logic [N_IN*DATA_W-1:0]   in_data;
    logic                     out_valid;
    logic [SUM_W-1:0]         out_sum;
    logic [DATA_W-1:0]        out_mean;

    modport master (
        output en,
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_sum,
        input  out_mean
    );

    modport slave (
        input  en,
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_sum,
        output out_mean
    );

endinterface

// File: rtl/add_tree_level.sv
// One registered adder-tree level: adjacent operands are summed left to right,
// an odd last operand is zero-extended and passed through, then everything is registered.
module add_tree_level #(
    parameter int N_OPS = 9,
    parameter int OP_W  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_en,
    input  logic                                   i_valid,
    input  logic [N_OPS*OP_W-1:0]                  i_ops,
    output logic                                   o_valid,
    output logic [((N_OPS+1)/2)*(OP_W+1)-1:0]      o_ops
);

    localparam int N_RES = (N_OPS + 1) / 2;
    localparam int RES_W = OP_W + 1;

    logic [N_RES*RES_W-1:0] w_res;
    logic [N_RES*RES_W-1:0] r_ops;
    logic                   r_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_RES; gi++) begin : g_pair
            if (2 * gi + 1 < N_OPS) begin : g_add
                assign w_res[gi*RES_W +: RES_W] = RES_W'(i_ops[(2*gi)*OP_W +: OP_W])
                                                + RES_W'(i_ops[(2*gi+1)*OP_W +: OP_W]);
            end else begin : g_pass
                assign w_res[gi*RES_W +: RES_W] = RES_W'(i_ops[(2*gi)*OP_W +: OP_W]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_ops   <= w_res;
            r_valid <= i_valid;
        end
    end

    assign o_ops   = r_ops;
    assign o_valid = r_valid;

endmodule

// File: rtl/window_sum_pipe.sv
// Fully pipelined N-input window adder with valid tracking, global stall enable and
// an exact floor(sum/N_IN) mean computed in the output stage.
module window_sum_pipe
    import filter_pkg::*;
#(
    parameter int N_IN   = 9,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    window_sum_pipe_if.slave  bus
);

    localparam int SUM_W  = SUM_W_OF(N_IN, DATA_W);
    localparam int N_LVL  = CLOG2(N_IN);
    localparam int PROD_W = 2 * SUM_W;
    localparam logic [SUM_W-1:0] RECIP = SUM_W'(RECIP_OF(N_IN, SUM_W));

    logic [N_IN*DATA_W-1:0] r_data;
    logic                   r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (bus.en) begin
            r_data  <= bus.in_data;
            r_valid <= bus.in_valid;
        end
    end

    // Each level reads the previous level's registered outputs; level 0 reads the input stage.
    genvar gi;
    generate
        for (gi = 0; gi < N_LVL; gi++) begin : g_lvl
            localparam int OPS   = LEVEL_OPS(N_IN, gi);
            localparam int OP_W  = DATA_W + gi;
            localparam int RES_W = ((OPS + 1) / 2) * (OP_W + 1);

            logic [OPS*OP_W-1:0] w_ops_in;
            logic                w_valid_in;
            logic [RES_W-1:0]    w_ops;
            logic                w_valid;

            if (gi == 0) begin : g_src
                assign w_ops_in   = r_data;
                assign w_valid_in = r_valid;
            end else begin : g_src
                assign w_ops_in   = g_lvl[gi-1].w_ops;
                assign w_valid_in = g_lvl[gi-1].w_valid;
            end

            add_tree_level #(
                .N_OPS (OPS),
                .OP_W  (OP_W)
            ) u_level (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (bus.en),
                .i_valid (w_valid_in),
                .i_ops   (w_ops_in),
                .o_valid (w_valid),
                .o_ops   (w_ops)
            );
        end
    endgenerate

    logic [SUM_W-1:0]  w_sum;
    logic              w_sum_valid;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_q_est;
    logic [SUM_W-1:0]  w_back;
    logic [SUM_W-1:0]  w_rem;
    logic [SUM_W-1:0]  w_q;

    assign w_sum       = SUM_W'(g_lvl[N_LVL-1].w_ops);
    assign w_sum_valid = g_lvl[N_LVL-1].w_valid;

    // Reciprocal estimate is q or q-1; one remainder test restores the exact quotient.
    assign w_prod  = PROD_W'(w_sum) * PROD_W'(RECIP);
    assign w_q_est = SUM_W'(w_prod >> SUM_W);
    assign w_back  = w_q_est * SUM_W'(N_IN);
    assign w_rem   = w_sum - w_back;
    assign w_q     = (w_rem >= SUM_W'(N_IN)) ? (w_q_est + SUM_W'(1)) : w_q_est;

    logic              r_out_valid;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_mean;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_mean      <= '0;
        end else if (bus.en) begin
            r_out_valid <= w_sum_valid;
            r_sum       <= w_sum;
            r_mean      <= DATA_W'(w_q);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_mean  = r_mean;

endmodule

// File: tb/tb_window_sum_pipe.sv
// Directed bench for window_sum_pipe at N_IN=9 and N_IN=25: latency, stall, reset,
// random streaming against a software sum model, and full-range mean sweeps.
module tb_window_sum_pipe;

    logic clk;
    logic rst_n;

    window_sum_pipe_if #(.N_IN(9),  .DATA_W(8)) ifa ();
    window_sum_pipe_if #(.N_IN(25), .DATA_W(8)) ifb ();

    window_sum_pipe #(.N_IN(9), .DATA_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    window_sum_pipe #(.N_IN(25), .DATA_W(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pix [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_valid(input int sel);
        return (sel != 0) ? 32'(ifb.out_valid) : 32'(ifa.out_valid);
    endfunction

    function automatic logic [31:0] obs_sum(input int sel);
        return (sel != 0) ? 32'(ifb.out_sum) : 32'(ifa.out_sum);
    endfunction

    function automatic logic [31:0] obs_mean(input int sel);
        return (sel != 0) ? 32'(ifb.out_mean) : 32'(ifa.out_mean);
    endfunction

    task automatic expect_out(input int sel, input string tag, input int v, input int s, input int m);
        check({tag, "_valid"}, obs_valid(sel), 32'(v));
        if (v != 0) begin
            check({tag, "_sum"},  obs_sum(sel),  32'(s));
            check({tag, "_mean"}, obs_mean(sel), 32'(m));
        end
    endtask

    task automatic drive(input int sel, input bit v);
        if (sel == 0) begin
            for (int k = 0; k < 9; k++) ifa.in_data[k*8 +: 8] = 8'(pix[k]);
            ifa.in_valid = v;
        end else begin
            for (int k = 0; k < 25; k++) ifb.in_data[k*8 +: 8] = 8'(pix[k]);
            ifb.in_valid = v;
        end
    endtask

    function automatic int model_sum(input int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) s += pix[k];
        return s;
    endfunction

    // mode 0: random pixels; mode 1: pixels packed greedily so the window sums to idx; mode 2: all cval.
    task automatic fill(input int mode, input int idx, input int n, input int cval);
        int rem;
        rem = idx;
        for (int k = 0; k < 64; k++) pix[k] = 0;
        for (int k = 0; k < n; k++) begin
            if (mode == 0) begin
                pix[k] = int'($urandom_range(0, 255));
            end else if (mode == 1) begin
                pix[k] = (rem > 255) ? 255 : rem;
                rem -= pix[k];
            end else begin
                pix[k] = cval;
            end
        end
    endtask

    task automatic run_stream(input int sel, input int count, input int mode, input bit verbose,
                              input string tag);
        int n;
        int lat;
        int j;
        int exp_q [$];
        n   = (sel != 0) ? 25 : 9;
        lat = (sel != 0) ? 7 : 6;
        for (int i = 0; i < count + lat; i++) begin
            if (i < count) begin
                fill(mode, i, n, 0);
                exp_q.push_back(model_sum(n));
                drive(sel, 1'b1);
            end else begin
                drive(sel, 1'b0);
            end
            tick();
            j = i - (lat - 1);
            if (j >= 0 && j < count) begin
                expect_out(sel, tag, 1, exp_q[j], exp_q[j] / n);
                if (verbose)
                    $display("%s[%0d]: sum=%0d mean=%0d expected_sum=%0d", tag, j,
                             obs_sum(sel), obs_mean(sel), exp_q[j]);
            end else begin
                check({tag, "_idle"}, obs_valid(sel), 32'd0);
            end
        end
        $display("%s: %0d windows streamed", tag, count);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b1;
        ifa.en       = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_data  = '0;
        ifb.en       = 1'b0;
        ifb.in_valid = 1'b0;
        ifb.in_data  = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        expect_out(0, "rst_a", 0, 0, 0);
        check("rst_a_sum",  obs_sum(0),  32'd0);
        check("rst_a_mean", obs_mean(0), 32'd0);
        expect_out(1, "rst_b", 0, 0, 0);
        check("rst_b_sum",  obs_sum(1),  32'd0);
        $display("reset: a_valid=%0d a_sum=%0d b_valid=%0d", obs_valid(0), obs_sum(0), obs_valid(1));
        rst_n  = 1'b1;
        ifa.en = 1'b1;
        ifb.en = 1'b1;
        tick();
        tick();

        // All 255, exact latency of 6 enabled cycles.
        fill(2, 0, 9, 255);
        drive(0, 1'b1);
        tick();
        drive(0, 1'b0);
        check("a255_early", obs_valid(0), 32'd0);
        for (int t = 2; t < 6; t++) begin
            tick();
            check("a255_early", obs_valid(0), 32'd0);
        end
        tick();
        expect_out(0, "a255", 1, 2295, 255);
        $display("a255: sum=%0d mean=%0d", obs_sum(0), obs_mean(0));
        tick();
        check("a255_after", obs_valid(0), 32'd0);

        // Pixels 1..9 then a floor check, back to back.
        for (int k = 0; k < 9; k++) pix[k] = k + 1;
        drive(0, 1'b1);
        tick();
        fill(2, 0, 9, 0);
        pix[0] = 10;
        drive(0, 1'b1);
        tick();
        drive(0, 1'b0);
        for (int t = 0; t < 4; t++) tick();
        expect_out(0, "a_ramp", 1, 45, 5);
        $display("a_ramp: sum=%0d mean=%0d", obs_sum(0), obs_mean(0));
        tick();
        expect_out(0, "a_floor", 1, 10, 1);
        $display("a_floor: sum=%0d mean=%0d", obs_sum(0), obs_mean(0));
        tick();
        check("a_floor_after", obs_valid(0), 32'd0);

        run_stream(0, 20, 0, 1'b1, "a_rand");

        // Stall for three cycles while the window is mid-tree.
        for (int k = 0; k < 9; k++) pix[k] = k + 1;
        drive(0, 1'b1);
        tick();
        drive(0, 1'b0);
        tick();
        tick();
        ifa.en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("a_stall_mid", obs_valid(0), 32'd0);
        end
        ifa.en = 1'b1;
        tick();
        check("a_stall_wait", obs_valid(0), 32'd0);
        tick();
        check("a_stall_wait", obs_valid(0), 32'd0);
        tick();
        expect_out(0, "a_stall_out", 1, 45, 5);
        $display("a_stall_out: sum=%0d mean=%0d", obs_sum(0), obs_mean(0));
        // Outputs hold under stall; the window offered meanwhile must be dropped.
        ifa.en = 1'b0;
        fill(2, 0, 9, 7);
        drive(0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            tick();
            expect_out(0, "a_stall_hold", 1, 45, 5);
        end
        ifa.en = 1'b1;
        drive(0, 1'b0);
        for (int t = 0; t < 7; t++) begin
            tick();
            check("a_stall_drop", obs_valid(0), 32'd0);
        end

        // Reset with windows in flight.
        fill(2, 0, 9, 50);
        for (int w = 0; w < 3; w++) begin
            drive(0, 1'b1);
            tick();
        end
        drive(0, 1'b0);
        tick();
        tick();
        tick();
        expect_out(0, "a_pre_rst", 1, 450, 50);
        rst_n = 1'b0;
        #2;
        expect_out(0, "a_async_rst", 0, 0, 0);
        check("a_async_rst_sum",  obs_sum(0),  32'd0);
        check("a_async_rst_mean", obs_mean(0), 32'd0);
        $display("a_async_rst: valid=%0d sum=%0d", obs_valid(0), obs_sum(0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            check("a_post_rst_idle", obs_valid(0), 32'd0);
        end
        fill(2, 0, 9, 100);
        drive(0, 1'b1);
        tick();
        drive(0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            check("a_post_rst_early", obs_valid(0), 32'd0);
            tick();
        end
        expect_out(0, "a_post_rst", 1, 900, 100);
        $display("a_post_rst: sum=%0d mean=%0d", obs_sum(0), obs_mean(0));
        tick();

        run_stream(0, 2296, 1, 1'b0, "a_sweep");

        // N_IN=25: all 255 with latency 7.
        fill(2, 0, 25, 255);
        drive(1, 1'b1);
        tick();
        drive(1, 1'b0);
        for (int t = 1; t < 7; t++) begin
            check("b255_early", obs_valid(1), 32'd0);
            tick();
        end
        expect_out(1, "b255", 1, 6375, 255);
        $display("b255: sum=%0d mean=%0d", obs_sum(1), obs_mean(1));
        tick();
        check("b255_after", obs_valid(1), 32'd0);

        run_stream(1, 10, 0, 1'b1, "b_rand");
        run_stream(1, 6376, 1, 1'b0, "b_sweep");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
